// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int unsigned FETCH_ADDR_WIDTH  = 32;
    localparam int unsigned FETCH_INSTR_WIDTH = 32;
    localparam int unsigned INSTR_BYTES       = 4;

    localparam logic [FETCH_ADDR_WIDTH-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [FETCH_INSTR_WIDTH-1:0] instr;
        logic [FETCH_ADDR_WIDTH-1:0]  pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular FIFO with a registered head; flush empties it and dominates push/pop.
module fetch_queue #(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned DATA_W = 64
) (
    input  logic                       clock,
    input  logic                       resetN,
    input  logic                       flush,
    input  logic                       push,
    input  logic [DATA_W-1:0]          pushData,
    input  logic                       pop,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       headValid,
    output logic [DATA_W-1:0]          headData
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wrPtr;
    logic [PTR_W-1:0]  rdPtr;
    logic [PTR_W-1:0]  rdPtrNext;
    logic [CNT_W-1:0]  countNext;
    logic              doPush;
    logic              doPop;

    function automatic logic [PTR_W-1:0] ptrInc(input logic [PTR_W-1:0] p);
        return (32'(p) == DEPTH - 1) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        doPop     = pop && (count != '0);
        doPush    = push && ((count != CNT_W'(DEPTH)) || doPop);
        rdPtrNext = doPop ? ptrInc(rdPtr) : rdPtr;
        countNext = count + CNT_W'(doPush) - CNT_W'(doPop);
    end

    // Head is precomputed for the next cycle so decode sees a plain register.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            count     <= '0;
            headValid <= 1'b0;
            headData  <= '0;
        end else if (flush) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            count     <= '0;
            headValid <= 1'b0;
        end else begin
            if (doPush) begin
                wrPtr <= ptrInc(wrPtr);
            end
            rdPtr     <= rdPtrNext;
            count     <= countNext;
            headValid <= (countNext != '0);
            if (countNext != '0) begin
                headData <= (doPush && (wrPtr == rdPtrNext)) ? pushData : mem[rdPtrNext];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (doPush && !flush) begin
            mem[wrPtr] <= pushData;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the fetch PC, issues single outstanding I-cache requests,
// buffers returned words and hands them to decode; branches flush and redirect.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned            ADDR_WIDTH  = FETCH_ADDR_WIDTH,
    parameter int unsigned            INSTR_WIDTH = FETCH_INSTR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0]  RESET_PC    = ADDR_WIDTH'(DEFAULT_RESET_PC),
    parameter int unsigned            QUEUE_DEPTH = 2
) (
    input  logic                   clock,
    input  logic                   resetN,
    input  logic                   branchTaken,
    input  logic [ADDR_WIDTH-1:0]  branchTarget,
    output logic                   imemReq,
    output logic [ADDR_WIDTH-1:0]  imemAddr,
    input  logic                   imemAck,
    input  logic [INSTR_WIDTH-1:0] imemData,
    output logic                   instrValid,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic [ADDR_WIDTH-1:0]  instrPC,
    input  logic                   instrReady
);

    localparam int unsigned CNT_W   = $clog2(QUEUE_DEPTH + 1);
    localparam int unsigned ENTRY_W = INSTR_WIDTH + ADDR_WIDTH;

    fetch_state_t          state;
    fetch_state_t          stateNext;
    logic [ADDR_WIDTH-1:0] fetchPc;
    logic [ADDR_WIDTH-1:0] fetchPcNext;
    logic [ADDR_WIDTH-1:0] imemAddrNext;
    logic [ADDR_WIDTH-1:0] targetAligned;
    logic [CNT_W-1:0]      queueCount;
    logic [CNT_W-1:0]      countNext;
    logic                  roomNext;
    logic                  push;
    logic                  pop;
    logic [ENTRY_W-1:0]    headData;

    assign push          = (state == REQ) && imemAck && !branchTaken;
    assign pop           = instrValid && instrReady && !branchTaken;
    assign targetAligned = branchTarget & ~ADDR_WIDTH'(INSTR_BYTES - 1);

    fetch_queue #(
        .DEPTH  (QUEUE_DEPTH),
        .DATA_W (ENTRY_W)
    ) u_queue (
        .clock     (clock),
        .resetN    (resetN),
        .flush     (branchTaken),
        .push      (push),
        .pushData  ({imemData, fetchPc}),
        .pop       (pop),
        .count     (queueCount),
        .headValid (instrValid),
        .headData  (headData)
    );

    assign instruction = headData[ENTRY_W-1 -: INSTR_WIDTH];
    assign instrPC     = headData[ADDR_WIDTH-1:0];

    // Next state, next PC and next request address; a redirect overrides push/pop.
    always_comb begin
        stateNext   = state;
        fetchPcNext = fetchPc;
        countNext   = branchTaken ? '0 : queueCount + CNT_W'(push) - CNT_W'(pop);
        roomNext    = (countNext < CNT_W'(QUEUE_DEPTH));

        if (branchTaken) begin
            fetchPcNext = targetAligned;
        end else if (push) begin
            fetchPcNext = fetchPc + ADDR_WIDTH'(INSTR_BYTES);
        end

        case (state)
            IDLE: begin
                if (branchTaken || roomNext) begin
                    stateNext = REQ;
                end
            end
            REQ: begin
                if (branchTaken) begin
                    stateNext = imemAck ? REQ : DROP;
                end else if (imemAck) begin
                    stateNext = roomNext ? REQ : IDLE;
                end
            end
            DROP: begin
                if (!branchTaken && imemAck) begin
                    stateNext = REQ;
                end
            end
            default: stateNext = IDLE;
        endcase

        // DROP keeps presenting the stale address until its response returns.
        imemAddrNext = (stateNext == DROP) ? imemAddr : fetchPcNext;
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state    <= IDLE;
            fetchPc  <= RESET_PC;
            imemReq  <= 1'b0;
            imemAddr <= RESET_PC;
        end else begin
            state    <= stateNext;
            fetchPc  <= fetchPcNext;
            imemReq  <= (stateNext != IDLE);
            imemAddr <= imemAddrNext;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed scoreboard bench for fetch_unit.
module tb_fetch_unit;
    import fetch_pkg::*;

    logic        clock;
    logic        resetN;
    logic        branchTaken;
    logic [31:0] branchTarget;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemAck;
    logic [31:0] imemData;
    logic        instrValid;
    logic [31:0] instruction;
    logic [31:0] instrPC;
    logic        instrReady;

    int compared   = 0;
    int mismatched = 0;
    fetch_entry_t sb[$];

    fetch_unit dut (
        .clock        (clock),
        .resetN       (resetN),
        .branchTaken  (branchTaken),
        .branchTarget (branchTarget),
        .imemReq      (imemReq),
        .imemAddr     (imemAddr),
        .imemAck      (imemAck),
        .imemData     (imemData),
        .instrValid   (instrValid),
        .instruction  (instruction),
        .instrPC      (instrPC),
        .instrReady   (instrReady)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $error("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Score any pop happening on the coming edge, then advance one cycle.
    task automatic tick();
        fetch_entry_t e;
        if (instrValid && instrReady && !branchTaken) begin
            if (sb.size() == 0) begin
                check("sbUnderflow", 64'(sb.size()), 64'(1));
            end else begin
                e = sb.pop_front();
                check("popPC", 64'(instrPC), 64'(e.pc));
                check("popInstr", 64'(instruction), 64'(e.instr));
            end
        end
        if (branchTaken) sb.delete();
        @(posedge clock);
        #1;
    endtask

    task automatic clearIn();
        branchTaken  = 1'b0;
        branchTarget = '0;
        imemAck      = 1'b0;
        imemData     = '0;
        instrReady   = 1'b0;
    endtask

    task automatic ackStep(input logic [31:0] data, input logic [31:0] expAddr, input bit keep);
        check("ackReq", 64'(imemReq), 64'(1));
        check("ackAddr", 64'(imemAddr), 64'(expAddr));
        imemAck  = 1'b1;
        imemData = data;
        if (keep) sb.push_back('{instr: data, pc: expAddr});
        tick();
        imemAck = 1'b0;
    endtask

    task automatic restart();
        resetN = 1'b0;
        clearIn();
        tick();
        sb.delete();
        resetN = 1'b1;
        check("relReq0", 64'(imemReq), 64'(0));
        tick();
        check("relReq1", 64'(imemReq), 64'(1));
        check("relAddr", 64'(imemAddr), 64'(32'h0));
    endtask

    initial begin
        resetN = 1'b0;
        clearIn();
        #1;

        // Reset with random inputs
        for (int i = 0; i < 4; i++) begin
            branchTaken  = 1'($urandom_range(0, 1));
            branchTarget = $urandom;
            imemAck      = 1'($urandom_range(0, 1));
            imemData     = $urandom;
            instrReady   = 1'($urandom_range(0, 1));
            tick();
            check("rstReq", 64'(imemReq), 64'(0));
            check("rstAddr", 64'(imemAddr), 64'(0));
            check("rstValid", 64'(instrValid), 64'(0));
            check("rstInstr", 64'(instruction), 64'(0));
            check("rstPC", 64'(instrPC), 64'(0));
        end
        clearIn();
        sb.delete();
        resetN = 1'b1;
        check("relReq0", 64'(imemReq), 64'(0));
        tick();
        check("relReq1", 64'(imemReq), 64'(1));
        check("relAddr", 64'(imemAddr), 64'(0));

        // Streaming, ack every cycle
        instrReady = 1'b1;
        ackStep(32'h8B020020, 32'h0, 1'b1);
        check("strValid0", 64'(instrValid), 64'(1));
        check("strPC0", 64'(instrPC), 64'(32'h0));
        ackStep(32'hCB030041, 32'h4, 1'b1);
        check("strValid1", 64'(instrValid), 64'(1));
        ackStep(32'h8A040062, 32'h8, 1'b1);
        check("strValid2", 64'(instrValid), 64'(1));
        check("strAddr12", 64'(imemAddr), 64'(32'hC));
        check("strReq12", 64'(imemReq), 64'(1));
        tick();
        check("strDrained", 64'(instrValid), 64'(0));

        // Backpressure fills the queue and stops requests
        restart();
        instrReady = 1'b0;
        ackStep(32'h11110000, 32'h0, 1'b1);
        ackStep(32'h22220004, 32'h4, 1'b1);
        check("bpReqLow", 64'(imemReq), 64'(0));
        check("bpHeadPC", 64'(instrPC), 64'(32'h0));
        imemAck  = 1'b1;
        imemData = 32'hBADBAD00;
        tick();
        imemAck = 1'b0;
        check("bpStrayAck", 64'(imemReq), 64'(0));
        check("bpHeadHeld", 64'(instrPC), 64'(32'h0));
        instrReady = 1'b1;
        tick();
        check("bpReqResume", 64'(imemReq), 64'(1));
        check("bpAddr8", 64'(imemAddr), 64'(32'h8));
        check("bpHeadPC4", 64'(instrPC), 64'(32'h4));
        tick();
        check("bpEmpty", 64'(instrValid), 64'(0));

        // Redirect while a request is outstanding
        branchTaken  = 1'b1;
        branchTarget = 32'h40;
        tick();
        branchTaken = 1'b0;
        check("dropReq", 64'(imemReq), 64'(1));
        check("dropAddr", 64'(imemAddr), 64'(32'h8));
        tick();
        check("dropHold", 64'(imemAddr), 64'(32'h8));
        ackStep(32'hDEADBEEF, 32'h8, 1'b0);
        check("dropValid", 64'(instrValid), 64'(0));
        check("dropTgtAddr", 64'(imemAddr), 64'(32'h40));
        instrReady = 1'b0;
        ackStep(32'h33330040, 32'h40, 1'b1);
        check("tgtHeadPC", 64'(instrPC), 64'(32'h40));
        check("tgtValid", 64'(instrValid), 64'(1));

        // Simultaneous ack, pop and redirect
        check("simAddr", 64'(imemAddr), 64'(32'h44));
        instrReady   = 1'b1;
        branchTaken  = 1'b1;
        branchTarget = 32'h100;
        imemAck      = 1'b1;
        imemData     = 32'h12345678;
        tick();
        clearIn();
        check("simValid", 64'(instrValid), 64'(0));
        check("simReq", 64'(imemReq), 64'(1));
        check("simAddr100", 64'(imemAddr), 64'(32'h100));

        // Misaligned target near the top of the address space, then wrap
        branchTaken  = 1'b1;
        branchTarget = 32'hFFFF_FFFE;
        tick();
        clearIn();
        ackStep(32'h0, 32'h100, 1'b0);
        check("wrapTgt", 64'(imemAddr), 64'(32'hFFFF_FFFC));
        ackStep(32'h44440FFC, 32'hFFFF_FFFC, 1'b1);
        check("wrapAddr0", 64'(imemAddr), 64'(32'h0));
        check("wrapHeadPC", 64'(instrPC), 64'(32'hFFFF_FFFC));

        // Asynchronous reset between edges
        #2;
        resetN = 1'b0;
        #1;
        check("arstReq", 64'(imemReq), 64'(0));
        check("arstValid", 64'(instrValid), 64'(0));
        sb.delete();
        tick();
        resetN = 1'b1;
        tick();
        check("arstRestartReq", 64'(imemReq), 64'(1));
        check("arstRestartAddr", 64'(imemAddr), 64'(32'h0));
        instrReady = 1'b1;
        ackStep(32'h55550000, 32'h0, 1'b1);
        check("arstHeadPC", 64'(instrPC), 64'(32'h0));
        tick();
        check("sbEmpty", 64'(sb.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage that sits directly upstream of the Controller/decode path and downstream of the instruction cache. It owns the fetch PC and issues one-at-a-time requests to the instruction cache over a req/ack handshake. It buffers returned instructions in a small queue and hands them to decode over a valid/ready handshake. Branch redirects from the PC/branch logic flush the queue and restart fetch at the target.

Parameters:
ADDR_WIDTH, 32, width of fetch addresses and PCs
INSTR_WIDTH, 32, width of one instruction word
RESET_PC, 32'h0000_0000, first fetch address after reset
QUEUE_DEPTH, 2, instruction queue entries (>=1)

Ports:
clock  input  1  main clock, rising edge
resetN  input  1  asynchronous active-low reset
branchTaken  input  1  one-cycle redirect pulse, sampled on rising edge
branchTarget  input  ADDR_WIDTH  redirect address, valid with branchTaken
imemReq  output  1  fetch request to instruction cache
imemAddr  output  ADDR_WIDTH  fetch address, stable while imemReq high
imemAck  input  1  cache response; transaction completes on an edge with imemReq&imemAck
imemData  input  INSTR_WIDTH  instruction word, valid with imemAck
instrValid  output  1  queue head holds a valid instruction
instruction  output  INSTR_WIDTH  queue head instruction
instrPC  output  ADDR_WIDTH  address of queue head instruction
instrReady  input  1  decode accepts head; pop on edge with instrValid&instrReady

Behaviour:
- Reset: resetN is asynchronous and active-low. While it is low: imemReq=0, imemAddr=RESET_PC, instrValid=0, instruction=0, instrPC=0, queue count=0, state=IDLE, fetchPC=RESET_PC.
- All outputs come from registers. There is no combinational input-to-output path.
- At most one outstanding request. imemAddr and imemReq do not change until the ack edge.
- FSM states:
  - IDLE: imemReq=0. Go to REQ when count_next < QUEUE_DEPTH.
  - REQ: imemReq=1 at fetchPC. On ack with no branch: push {imemData, fetchPC} and set fetchPC+=4. Stay in REQ (back-to-back, addr+4) if count_next < QUEUE_DEPTH, else go to IDLE.
  - DROP: imemReq=1 at the stale address. On ack, discard the data and go to REQ at fetchPC (the already-loaded target).
- count_next = count + push - pop. A push and a pop may occur on the same edge.
- Minimum latency: imemReq rises on the first edge after resetN deasserts. An ack on edge N makes instrValid high after edge N when the queue was empty.
- Throughput: one instruction per cycle when the cache acks every cycle and decode is ready.
- Redirect (branchTaken on an edge) has priority over push and pop on that edge:
  - Queue flushed: count=0, so instrValid=0 after the edge. A same-edge pop is not counted as consumed.
  - fetchPC=branchTarget.
  - In REQ without ack: go to DROP.
  - In REQ with ack on the same edge: data discarded, go to REQ at branchTarget.
  - In IDLE: go to REQ.
  - In DROP: stay in DROP with the target updated.
- PC arithmetic is modulo 2^ADDR_WIDTH; wrap from 0xFFFF_FFFC to 0 is legal. branchTarget[1:0] is ignored (forced 0).
- Queue full: no request is issued and no ack can arrive. An ack with imemReq low is ignored.
- Reset mid-transaction: imemReq drops immediately (asynchronously) and the outstanding response is abandoned. The cache must tolerate this.

Decomposition:
- Package fetch_pkg holds:
  - the fetch_state_t enum {IDLE, REQ, DROP};
  - INSTR_BYTES=4;
  - default RESET_PC;
  - a fetch_entry_t struct {instr, pc}.
- One sub-module, fetch_queue: a parameterised circular FIFO with push, pop, a synchronous flush (flush dominates), count, and head outputs. It uses the same clock and resetN.
- The FSM and PC logic stay in fetch_unit.

Test Plan:
1. Reset: hold resetN=0 with random inputs -> imemReq=0, imemAddr=0, instrValid=0. Release -> imemReq=1 and imemAddr=0 after the next edge.
2. Streaming: ack every cycle with data 0x8B020020, 0xCB030041, 0x8A040062; instrReady=1 -> instrValid stays high from the cycle after the first ack, instrPC=0,4,8 in order, imemAddr=0,4,8,12.
3. Backpressure: instrReady=0, ack every cycle -> after 2 acks imemReq=0, queue holds PC 0 and 4. Raise instrReady -> pops PC 0, then imemReq=1 at addr 8.
4. Redirect while waiting: request at addr 8 outstanding, branchTaken with target 0x40, ack 2 cycles later with 0xDEADBEEF -> data dropped, instrValid=0, next imemAddr=0x40, first delivered instrPC=0x40.
5. Simultaneous ack, pop and branch with target 0x100 -> acked word discarded, queue empty after the edge, imemReq=1 at 0x100 next cycle.
6. Async reset mid-request: drop resetN between edges while imemReq=1 and queue holds 1 entry -> imemReq=0 and instrValid=0 immediately. After release, fetch restarts at RESET_PC.
